// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch controller: FSM state encoding,
// default moduli of the mm:ss digit chain and the default digit width.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  localparam int DEF_MOD0    = 10;
  localparam int DEF_MOD1    = 6;
  localparam int DEF_MOD2    = 10;
  localparam int DEF_MOD3    = 6;
  localparam int DEF_DIGIT_W = 4;

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Time-base prescaler for the stopwatch: counts while run is high, holds
// while hold is high, otherwise sits at zero; Tick marks the last count.
module tick_gen
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hold,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_r;

  // Prescaler count: wrap in run, freeze in hold, zero otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= CW'(0);
    end else if (run) begin
      count_r <= (count_r == LAST) ? CW'(0) : count_r + CW'(1);
    end else if (hold) begin
      count_r <= count_r;
    end else begin
      count_r <= CW'(0);
    end
  end

  assign tick = run && (count_r == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for a four-stage mm:ss counter chain.
// Optional lap freeze of the display is built when LAP_FREEZE_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE = 50000000,
  parameter int MOD0     = DEF_MOD0,
  parameter int MOD1     = DEF_MOD1,
  parameter int MOD2     = DEF_MOD2,
  parameter int MOD3     = DEF_MOD3,
  parameter int DIGIT_W  = DEF_DIGIT_W
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 StartStop,
  input  logic                 Clear,
  input  logic                 Lap,
  input  logic [DIGIT_W-1:0]   Q0,
  input  logic [DIGIT_W-1:0]   Q1,
  input  logic [DIGIT_W-1:0]   Q2,
  input  logic [DIGIT_W-1:0]   Q3,
  output logic [3:0]           En,
  output logic                 Tick,
  output logic                 Running,
  output logic                 Busy,
  output logic [4*DIGIT_W-1:0] Disp
);

  localparam logic [DIGIT_W-1:0] LAST0 = DIGIT_W'(MOD0 - 1);
  localparam logic [DIGIT_W-1:0] LAST1 = DIGIT_W'(MOD1 - 1);
  localparam logic [DIGIT_W-1:0] LAST2 = DIGIT_W'(MOD2 - 1);
  localparam logic [DIGIT_W-1:0] ZERO  = DIGIT_W'(0);

  logic [1:0]           state_r;
  logic [1:0]           next_state_s;
  logic                 tick_s;
  logic                 all_zero_s;
  logic [4*DIGIT_W-1:0] q_bus_s;

  assign all_zero_s = (Q0 == ZERO) && (Q1 == ZERO) && (Q2 == ZERO) && (Q3 == ZERO);
  assign q_bus_s    = {Q3, Q2, Q1, Q0};

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk  (Clk),
    .rst  (Rst),
    .run  (state_r == ST_RUN),
    .hold (state_r == ST_PAUSE),
    .tick (tick_s)
  );

  // Next-state decode; Clear outranks StartStop except while running
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Clear) begin
          next_state_s = ST_CLEAR;
        end else if (StartStop) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (StartStop) begin
          next_state_s = ST_PAUSE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (Clear) begin
          next_state_s = ST_CLEAR;
        end else if (StartStop) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_PAUSE;
        end
      end
      ST_CLEAR: begin
        if (all_zero_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_CLEAR;
        end
      end
      default: next_state_s = ST_CLEAR;
    endcase
  end

  // State register; reset lands in CLEAR so the unreset digits get zeroed
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Stage enables: carry cascade while running, independent zeroing in CLEAR
  always_comb begin
    En = 4'b0000;
    case (state_r)
      ST_RUN: begin
        En[0] = tick_s;
        En[1] = tick_s && (Q0 == LAST0);
        En[2] = tick_s && (Q0 == LAST0) && (Q1 == LAST1);
        En[3] = tick_s && (Q0 == LAST0) && (Q1 == LAST1) && (Q2 == LAST2);
      end
      ST_CLEAR: begin
        En = {(Q3 != ZERO), (Q2 != ZERO), (Q1 != ZERO), (Q0 != ZERO)};
      end
      default: En = 4'b0000;
    endcase
  end

  assign Tick    = tick_s;
  assign Running = (state_r == ST_RUN);
  assign Busy    = (state_r == ST_CLEAR);

`ifdef LAP_FREEZE_EN
  logic                 freeze_r;
  logic [4*DIGIT_W-1:0] lap_r;

  // Lap toggles the freeze in RUN/PAUSE, capturing digits on set; CLEAR releases it
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      freeze_r <= 1'b0;
      lap_r    <= {(4*DIGIT_W){1'b0}};
    end else if (next_state_s == ST_CLEAR) begin
      freeze_r <= 1'b0;
      lap_r    <= lap_r;
    end else if (Lap && ((state_r == ST_RUN) || (state_r == ST_PAUSE))) begin
      freeze_r <= !freeze_r;
      lap_r    <= freeze_r ? lap_r : q_bus_s;
    end else begin
      freeze_r <= freeze_r;
      lap_r    <= lap_r;
    end
  end

  assign Disp = freeze_r ? lap_r : q_bus_s;
`else
  logic unused_lap_s;
  assign unused_lap_s = Lap;
  assign Disp         = q_bus_s;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for a four-digit mm:ss chain of modulo-N enable counters (stages 0..3 = seconds units, seconds tens, minutes units, minutes tens). It owns the time-base prescaler and the run/pause/clear state machine. It drives each stage's enable from its own state and the digit values it reads back, and provides a display bus. The counter stages have no reset, so this block zeroes them by sequencing their enables.

## Interface
- PRESCALE, 50000000: Clk cycles per count tick; must be at least 2.
- MOD0, 10: modulo of stage 0.
- MOD1, 6: modulo of stage 1.
- MOD2, 10: modulo of stage 2.
- MOD3, 6: modulo of stage 3.
- DIGIT_W, 4: width of each digit bus.
- Clk  in  1  single clock; all registers update on the rising edge; counter stages are configured to update on the same edge.
- Rst  in  1  reset, asynchronous, active-high.
- StartStop  in  1  one-cycle synchronous command pulse.
- Clear  in  1  one-cycle synchronous command pulse.
- Lap  in  1  one-cycle synchronous command pulse; ignored unless the Configuration macro is defined.
- Q0..Q3  in  DIGIT_W each  current digit values read back from stages 0..3.
- En  out  4  stage enables; En[k] drives stage k.
- Tick  out  1  time-base pulse.
- Running  out  1  high in RUN.
- Busy  out  1  high in CLEAR.
- Disp  out  4*DIGIT_W  display value, packed as {Q3,Q2,Q1,Q0}.

## Operation
- States: IDLE, RUN, PAUSE, CLEAR. Rst forces CLEAR, so digits are zeroed automatically after power-up.
- Reset values: prescaler count 0, Tick 0, Running 0, Busy 1, lap freeze 0, lap register 0.
- Prescaler:
  - Width is clog2(PRESCALE).
  - Counts 0..PRESCALE-1 in RUN only, wrapping to 0.
  - Holds its value in PAUSE.
  - Forced to 0 in IDLE and CLEAR.
- Tick = (state==RUN) and (count==PRESCALE-1).
- RUN enables:
  - En[0] = Tick.
  - En[k] = Tick and Qj==MODj-1 for all j<k.
  - 59:59 plus one tick wraps to 00:00 and stays in RUN.
- CLEAR enables:
  - En[k] = (Qk != 0), per stage and independently (no cascade).
  - Out-of-range digits (Qk >= MODk) wrap to 0 on their next enable.
  - When all Qk==0, go to IDLE; En is 0 in that cycle.
- Transitions:
  - IDLE: StartStop goes to RUN; Clear goes to CLEAR.
  - RUN: StartStop goes to PAUSE; Clear is ignored.
  - PAUSE: StartStop goes to RUN with the prescaler resuming from its held value; Clear goes to CLEAR.
  - CLEAR: all commands are ignored.
- Simultaneous StartStop and Clear:
  - In IDLE or PAUSE, Clear wins.
  - In RUN, StartStop applies.

## Timing
- En, Tick, Running, Busy and Disp are combinational decodes of registered state, the prescaler count, and Q0..Q3; latency from Q to En is zero.
- The first Tick after StartStop from IDLE occurs PRESCALE cycles after the command edge.
- StartStop arriving in a Tick cycle: that tick's enables take effect, then the state becomes PAUSE.
- CLEAR lasts at most max(MODk)-1 cycles from a valid digit state, or max(MODk) cycles from out-of-range digits, plus the exit cycle.
- Rst asserted mid-RUN: asynchronously goes to CLEAR; no further ticks are issued.

## Configuration
- LAP_FREEZE_EN, defined:
  - A Lap pulse in RUN or PAUSE toggles the freeze flag.
  - On set, the flag captures {Q3..Q0} into the lap register; Disp shows the lap register while frozen.
  - A Lap pulse in IDLE or CLEAR is ignored.
  - Entering CLEAR releases the freeze.
  - Counting continues underneath the freeze.
- Not defined: Lap is ignored, no lap register exists, and Disp = {Q3,Q2,Q1,Q0} always.

## Structure
- Shared package/include (stopwatch_pkg) holds:
  - state encoding constants (IDLE=0, RUN=1, PAUSE=2, CLEAR=3);
  - default moduli;
  - the digit width.
- One sub-module, tick_gen: prescaler with run/hold/zero controls and a Tick output.
- The FSM, enable decode and lap logic live in stopwatch_ctrl.

## Test plan
Simulation uses PRESCALE=4 with real counter stages attached.

1. Power-up digits 7,3,12,5, then Rst pulse: Busy high, digits reach 0,0,0,0 within 11 cycles, then IDLE with Busy=0.
2. StartStop from IDLE: Tick on cycles 4, 8, 12 after the command; digits read 0,0,0,3 after 3 ticks.
3. Preload 59:59, then one tick: all four En high in the same cycle; Disp=0x0000 next cycle; Running stays 1.
4. Pause with prescaler count 2, wait 20 cycles, resume: no Tick while paused; next Tick 1 cycle after resume.
5. In PAUSE, StartStop and Clear in the same cycle: CLEAR entered; digits zeroed; final state IDLE.
6. With LAP_FREEZE_EN defined, Lap at 00:05 in RUN, run 3 ticks: Disp holds 0x0005 while Q reads 00:08; second Lap makes Disp=0x0008.
